// File: rtl/lstm_pkg.sv
// Shared Q8.8 types, saturation limits and the gate MAC state encoding.
// Imported by the gate pre-activation MAC and the cell-state update stage.
package lstm_pkg;

  localparam int Q_FRAC_BITS = 8;

  typedef logic signed [15:0] q88_t;

  localparam q88_t Q_MAX = 16'sh7FFF;
  localparam q88_t Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ROUND = 2'd2
  } gate_mac_state_t;

endpackage

// File: rtl/sat_round.sv
// Round-half-up, arithmetic right shift by FRAC_BITS and saturation to Q8.8.
// Purely combinational; no handshake.
module sat_round
  import lstm_pkg::*;
#(
  parameter int IN_WIDTH  = 40,
  parameter int FRAC_BITS = Q_FRAC_BITS
) (
  input  logic signed [IN_WIDTH-1:0] din,
  output q88_t                       dout
);

  // One guard bit so adding the half-LSB can never wrap a near-max input.
  localparam logic signed [IN_WIDTH:0] HALF    = (IN_WIDTH+1)'(1) <<< (FRAC_BITS-1);
  localparam logic signed [IN_WIDTH:0] MAX_EXT = (IN_WIDTH+1)'(Q_MAX);
  localparam logic signed [IN_WIDTH:0] MIN_EXT = (IN_WIDTH+1)'(Q_MIN);

  logic signed [IN_WIDTH:0] sum;
  logic signed [IN_WIDTH:0] shifted;

  always_comb begin
    sum     = (IN_WIDTH+1)'(din) + HALF;
    shifted = sum >>> FRAC_BITS;
    if (shifted > MAX_EXT) begin
      dout = Q_MAX;
    end else if (shifted < MIN_EXT) begin
      dout = Q_MIN;
    end else begin
      dout = shifted[15:0];
    end
  end

endmodule

// File: rtl/gate_preact_mac.sv
// LSTM gate pre-activation z = bias + sum(w*x) in Q8.8, one pair per cycle.
// y_valid pulses 2 cycles after the last accepted beat; input stalls via in_ready, no output backpressure.
module gate_preact_mac
  import lstm_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int FRAC_BITS = Q_FRAC_BITS,
  parameter int ACC_WIDTH = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] bias,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic signed [15:0] y,
  output logic               y_valid
);

  localparam int               CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS - 1);

  gate_mac_state_t state, state_n;

  logic signed [ACC_WIDTH-1:0] acc;
  logic        [CNT_W-1:0]     cnt;
  logic signed [31:0]          prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic                        beat;
  q88_t                        r_sat;

  // Bias is pre-aligned to the Q16.16 grid of the products.
  assign prod     = 32'(x_in) * 32'(w_in);
  assign prod_ext = ACC_WIDTH'(prod);
  assign bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    beat     = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        beat     = in_valid;
        if (in_valid && (cnt == LAST)) begin
          state_n = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc <= bias_ext;
            cnt <= '0;
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ROUND: begin
          // y is only rewritten here, so it stays put for the lookup's ROM read.
          y       <= r_sat;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_round #(
    .IN_WIDTH  (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_round (
    .din  (acc),
    .dout (r_sat)
  );

endmodule

// File: tb/tb_gate_preact_mac.sv
// Bench for gate_preact_mac with N_INPUTS=4: scenario tasks plus a scoreboard
// of expected y values that a negedge monitor pops on every y_valid.
module tb_gate_preact_mac;

  typedef int vec4_t[4];

  logic               clk = 1'b0;
  logic               rst;
  logic               start = 1'b0;
  logic signed [15:0] bias = '0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] w_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               busy;
  logic signed [15:0] y;
  logic               y_valid;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] mon_e;

  gate_preact_mac #(
    .N_INPUTS  (4),
    .FRAC_BITS (8),
    .ACC_WIDTH (40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .x_in     (x_in),
    .w_in     (w_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .y        (y),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  // Reference: exact sum in Q16.16, round half up, saturate.
  function automatic logic signed [15:0] model(input int b, input vec4_t xs, input vec4_t ws);
    longint s;
    longint r;
    s = longint'(b) * 256;
    for (int i = 0; i < 4; i++) s += longint'(xs[i]) * longint'(ws[i]);
    r = (s + 128) >>> 8;
    if (r > 32767) return 16'sh7FFF;
    if (r < -32768) return 16'sh8000;
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && y_valid === 1'b1) begin
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_y_valid: y=%0d with no result pending", y);
      end else begin
        mon_e = exp_q.pop_front();
        if (y !== mon_e) begin
          errors++;
          $display("FAIL y_value: got %0d expected %0d", y, mon_e);
        end
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic start_op(input logic signed [15:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic signed [15:0] x, input logic signed [15:0] w);
    in_valid = 1'b1;
    x_in     = x;
    w_in     = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = '0;
    w_in     = '0;
  endtask

  task automatic run_vec(input int b, input vec4_t xs, input vec4_t ws);
    exp_q.push_back(model(b, xs, ws));
    start_op(16'(b));
    for (int i = 0; i < 4; i++) beat(16'(xs[i]), 16'(ws[i]));
  endtask

  task automatic wait_yv(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (y_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks += 4;
    if (y !== 16'sd0)     begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    vec4_t xs = '{256, 256, 256, 256};
    vec4_t ws = '{128, 128, 128, 128};
    exp_q.push_back(model(0, xs, ws));
    start_op(16'sd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready beat %0d: got %b expected 1", i, in_ready); end
      beat(16'(xs[i]), 16'(ws[i]));
    end
    checks += 2;
    if (y_valid !== 1'b0)  begin errors++; $display("FAIL basic_early_y_valid: got %b expected 0", y_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_drop: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (y_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: y_valid got %b expected 1", y_valid); end
    @(posedge clk); #1;
    checks += 3;
    if (y_valid !== 1'b0)  begin errors++; $display("FAIL basic_pulse_width: y_valid got %b expected 0", y_valid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
    if (y !== 16'sd512)    begin errors++; $display("FAIL basic_y_hold: got %0d expected 512", y); end
  endtask

  task automatic test_round_and_sat;
    vec4_t xa = '{256, 0, 0, 0};
    vec4_t xb = '{1, 0, 0, 0};
    vec4_t wb = '{128, 0, 0, 0};
    vec4_t xm = '{32767, 32767, 32767, 32767};
    vec4_t wn = '{-32768, -32768, -32768, -32768};
    int    bs[4];
    vec4_t xv[4];
    vec4_t wv[4];
    bit    seen;
    bs[0] = -384; xv[0] = xa; wv[0] = xa;
    bs[1] = 0;    xv[1] = xb; wv[1] = wb;
    bs[2] = 0;    xv[2] = xm; wv[2] = xm;
    bs[3] = 0;    xv[3] = xm; wv[3] = wn;
    for (int t = 0; t < 4; t++) begin
      run_vec(bs[t], xv[t], wv[t]);
      wait_yv(10, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL round_sat_timeout case %0d: y_valid got 0 expected 1", t); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gaps;
    bit   pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int   v0;
    vec4_t xs = '{256, 256, 256, 256};
    vec4_t ws = '{128, 128, 128, 128};
    exp_q.push_back(model(0, xs, ws));
    v0 = vcount;
    start_op(16'sd0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL gaps_in_ready step %0d: got %b expected 1", i, in_ready); end
      if (pat[i]) beat(16'sd256, 16'sd128);
      else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    x_in     = 16'sd32767;
    w_in     = 16'sd32767;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL gaps_extra_beat step %0d: in_ready got %b expected 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    x_in     = '0;
    w_in     = '0;
    checks++;
    if (vcount !== v0 + 1) begin errors++; $display("FAIL gaps_result_count: got %0d expected %0d", vcount - v0, 1); end
  endtask

  task automatic test_back_to_back;
    vec4_t xs = '{256, 256, 256, 256};
    vec4_t ws = '{128, 128, 128, 128};
    vec4_t zz = '{0, 0, 0, 0};
    bit    seen;
    run_vec(0, xs, ws);
    wait_yv(10, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_first_timeout: y_valid got 0 expected 1"); end
    exp_q.push_back(model(256, zz, zz));
    start_op(16'sd256);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        start = 1'b1;
        bias  = 16'sh1234;
      end
      beat(16'sd0, 16'sd0);
      start = 1'b0;
      checks++;
      if (y !== 16'sd512 || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold cycle %0d: y=%0d y_valid=%b expected y=512 y_valid=0", i + 1, y, y_valid);
      end
    end
    @(posedge clk); #1;
    checks += 2;
    if (y_valid !== 1'b1) begin errors++; $display("FAIL b2b_period: y_valid got %b expected 1", y_valid); end
    if (y !== 16'sd256)   begin errors++; $display("FAIL b2b_second_y: got %0d expected 256", y); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    vec4_t xs = '{256, 0, 0, 0};
    vec4_t ws = '{128, 0, 0, 0};
    int    v0;
    bit    seen;
    start_op(16'sd256);
    beat(16'sd256, 16'sd256);
    beat(16'sd256, 16'sd256);
    rst = 1'b1;
    #1;
    checks += 4;
    if (y !== 16'sd0)      begin errors++; $display("FAIL midrst_y: got %0d expected 0", y); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (y_valid !== 1'b0)  begin errors++; $display("FAIL midrst_y_valid: got %b expected 0", y_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    v0  = vcount;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checks++;
    if (vcount !== v0) begin errors++; $display("FAIL midrst_no_y_valid: pulses got %0d expected 0", vcount - v0); end
    run_vec(0, xs, ws);
    wait_yv(10, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_fresh_timeout: y_valid got 0 expected 1"); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_and_sat();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
